wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

- Sequential arbiter for the single write port of the 4×8-bit register file.
- Serves two requesters:
  - the pipeline write-back result;
  - the stack-pointer update. SP lives in R3.
- POP and similar instructions write both Rd and SP in the same cycle. The arbiter serializes them through a 2-entry SP queue and drives the register-file write port from a register.
- When the queue is full it raises a stall request to the hazard unit.

## Interface

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 2, register address width
- SP_ADDR, 2'd3, register index holding SP
- QDEPTH, 2, SP queue depth (fixed at 2)
- SP_RST, 8'hFF, SP value after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_wen  in  1  pipeline data write request, one cycle per request
- wb_addr  in  ADDR_W  destination register of the data write
- wb_data  in  DATA_W  data-write value
- sp_wen  in  1  SP update request
- sp_data  in  DATA_W  new SP value
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- stall_req  out  1  queue full; hazard unit must bubble write-back next cycle
- q_count  out  2  SP queue occupancy, 0..2
- sp_shadow  out  DATA_W  newest accepted SP value, used for forwarding
- ovf_err  out  1  sticky; an SP request was dropped on overflow

## Operation

Queue states: EMPTY (q_count=0), ONE (1), FULL (2).

Per-cycle priority, evaluated in this order:
1. **wb_wen=1 and wb_addr=SP_ADDR.**
   - Explicit write to R3 wins the port.
   - Queue is flushed to EMPTY; those entries are older and now dead.
   - A same-cycle sp_wen is discarded. ovf_err is not set.
   - sp_shadow ← wb_data.
2. **wb_wen=1, other address.**
   - Data write wins the port.
   - A same-cycle sp_wen is enqueued if q_count<2.
   - Otherwise it is dropped and ovf_err is set.
3. **wb_wen=0, queue non-empty.**
   - Port writes the queue head to SP_ADDR and pops it.
   - A same-cycle sp_wen is enqueued in the same cycle; occupancy is unchanged. This is legal even when FULL.
4. **wb_wen=0, queue empty, sp_wen=1.**
   - Direct write of sp_data to SP_ADDR; nothing is enqueued.
5. **Otherwise:** rf_wen=0. rf_waddr and rf_wdata hold their previous values.

Other rules:
- Every accepted sp_wen (enqueued or direct) sets sp_shadow ← sp_data.
- Queue order is FIFO. SP writes reach the register file in request order.
- stall_req = (q_count==2), decoded from the registered count; no combinational input path.
- ovf_err clears only on reset.

## Timing

- rf_* outputs appear exactly 1 cycle after the winning request.
- A queued SP entry is written no earlier than the first cycle with wb_wen=0 after it is enqueued.
- sp_shadow and q_count update on the same edge that accepts the request.
- stall_req asserts the cycle after the queue reaches FULL. It deasserts the cycle after the first drain that does not coincide with an enqueue.
- Reset values (asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, q_count=0, stall_req=0, sp_shadow=SP_RST, ovf_err=0.
- Queue pointers reset to 0.
- Reset mid-drain discards queued entries. No partial write is issued.

## Structure

- Package wb_arb_pkg holds:
  - DATA_W, ADDR_W, SP_ADDR, SP_RST;
  - enum q_state_t {Q_EMPTY, Q_ONE, Q_FULL}.
- Sub-module sp_queue contains:
  - 2-entry circular FIFO with 1-bit read/write pointers and 2-bit count;
  - ports push, pop, flush, din, dout, count;
  - simultaneous push+pop on FULL is legal.
- Top level contains the priority mux, the output registers, sp_shadow and ovf_err.

## Test plan

1. **Direct SP write.** From EMPTY, sp_wen=1, sp_data=8'hFE, wb_wen=0.
   - Next cycle: rf_wen=1, rf_waddr=3, rf_wdata=8'hFE.
   - q_count stays 0; sp_shadow=8'hFE.
2. **POP.** wb_wen=1, wb_addr=1, wb_data=8'h5A and sp_wen=1, sp_data=8'hFF in the same cycle.
   - Cycle+1: R1←8'h5A, q_count=1.
   - Cycle+2, with idle inputs: R3←8'hFF, q_count=0.
3. **Back-to-back POPs.** Three consecutive POPs with SP values 8'hFD, 8'hFE, 8'hFF.
   - stall_req=1 after the second.
   - Third SP value dropped; ovf_err=1.
   - Drain writes R3=8'hFD then 8'hFE, in order.
4. **Explicit R3 write.** With q_count=2, wb_wen=1, wb_addr=3, wb_data=8'h80, sp_wen=1.
   - Next cycle: R3←8'h80, q_count=0, sp_shadow=8'h80.
   - No later R3 writes from the queue; ovf_err unchanged.
5. **Push+pop on FULL.** With FULL, wb_wen=0, sp_wen=1.
   - Head is written to R3.
   - New entry is enqueued; q_count stays 2 and stall_req stays 1.
6. **Reset mid-drain.** Assert rst_n=0 with q_count=2.
   - Immediately: rf_wen=0, q_count=0, stall_req=0, sp_shadow=8'hFF, ovf_err=0.
   - No R3 write after release.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared parameters and types for the register-file write-port arbiter.
// Imported by the interface, the SP queue and the arbiter top.
package wb_arb_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int QDEPTH = 2;

    localparam logic [ADDR_W-1:0] SP_ADDR = 2'd3;
    localparam logic [DATA_W-1:0] SP_RST  = 8'hFF;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of requester inputs and register-file / status outputs.
// The pipeline side uses master, the arbiter uses slave.
interface wb_port_arbiter_if;
    import wb_arb_pkg::*;

    logic              wb_wen;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              sp_wen;
    logic [DATA_W-1:0] sp_data;

    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_req;
    logic [1:0]        q_count;
    logic [DATA_W-1:0] sp_shadow;
    logic              ovf_err;

    modport master (
        output wb_wen, wb_addr, wb_data,
        output sp_wen, sp_data,
        input  rf_wen, rf_waddr, rf_wdata,
        input  stall_req, q_count,
        input  sp_shadow, ovf_err
    );

    modport slave (
        input  wb_wen, wb_addr, wb_data,
        input  sp_wen, sp_data,
        output rf_wen, rf_waddr, rf_wdata,
        output stall_req, q_count,
        output sp_shadow, ovf_err
    );

endinterface

// File: rtl/sp_queue.sv
// Two-entry circular FIFO holding deferred stack-pointer writes.
// Push and pop together on a full queue is legal and keeps it full.
module sp_queue
    import wb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    q_state_t          state_q, state_d;
    logic              wp_q, wp_d;
    logic              rp_q, rp_d;
    logic [DATA_W-1:0] mem_q [QDEPTH];
    logic [DATA_W-1:0] mem_d [QDEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= Q_EMPTY;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        mem_d   = mem_q;
        if (flush) begin
            wp_d = 1'b0;
            rp_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wp_q] = din;
                wp_d        = ~wp_q;
            end
            if (pop) begin
                rp_d = ~rp_q;
            end
        end
        unique case (1'b1)
            flush: begin
                state_d = Q_EMPTY;
            end
            !flush && push && !pop: begin
                state_d = (state_q == Q_EMPTY) ? Q_ONE : Q_FULL;
            end
            !flush && pop && !push: begin
                state_d = (state_q == Q_FULL) ? Q_ONE : Q_EMPTY;
            end
            default: begin
            end
        endcase
    end

    assign dout  = mem_q[rp_q];
    assign count = state_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by write-back and SP updates.
// SP updates that lose the port wait in a two-entry queue.
module wb_port_arbiter
    import wb_arb_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    wb_port_arbiter_if.slave   bus
);

    logic              rf_wen_q, rf_wen_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [DATA_W-1:0] sp_shadow_q, sp_shadow_d;
    logic              ovf_err_q, ovf_err_d;

    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    logic [DATA_W-1:0] q_dout;
    logic [1:0]        q_count;

    logic sel_sp_wr;
    logic sel_wb;
    logic sel_drain;
    logic sel_direct;
    logic q_empty;
    logic q_full;

    sp_queue u_sp_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (bus.sp_data),
        .dout  (q_dout),
        .count (q_count)
    );

    assign q_empty = (q_count == Q_EMPTY);
    assign q_full  = (q_count == Q_FULL);

    // Mutually exclusive selects, in priority order.
    assign sel_sp_wr  = bus.wb_wen && (bus.wb_addr == SP_ADDR);
    assign sel_wb     = bus.wb_wen && (bus.wb_addr != SP_ADDR);
    assign sel_drain  = !bus.wb_wen && !q_empty;
    assign sel_direct = !bus.wb_wen && q_empty && bus.sp_wen;

    always_comb begin
        rf_wen_d    = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        sp_shadow_d = sp_shadow_q;
        ovf_err_d   = ovf_err_q;
        q_push      = 1'b0;
        q_pop       = 1'b0;
        q_flush     = 1'b0;
        unique case (1'b1)
            sel_sp_wr: begin
                // Queued SP values are older than this write: drop them.
                rf_wen_d    = 1'b1;
                rf_waddr_d  = SP_ADDR;
                rf_wdata_d  = bus.wb_data;
                q_flush     = 1'b1;
                sp_shadow_d = bus.wb_data;
            end
            sel_wb: begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = bus.wb_addr;
                rf_wdata_d = bus.wb_data;
                if (bus.sp_wen) begin
                    if (!q_full) begin
                        q_push      = 1'b1;
                        sp_shadow_d = bus.sp_data;
                    end else begin
                        ovf_err_d = 1'b1;
                    end
                end
            end
            sel_drain: begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = SP_ADDR;
                rf_wdata_d = q_dout;
                q_pop      = 1'b1;
                if (bus.sp_wen) begin
                    q_push      = 1'b1;
                    sp_shadow_d = bus.sp_data;
                end
            end
            sel_direct: begin
                rf_wen_d    = 1'b1;
                rf_waddr_d  = SP_ADDR;
                rf_wdata_d  = bus.sp_data;
                sp_shadow_d = bus.sp_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            sp_shadow_q <= SP_RST;
            ovf_err_q   <= 1'b0;
        end else begin
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            sp_shadow_q <= sp_shadow_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.stall_req = q_full;
    assign bus.q_count   = q_count;
    assign bus.sp_shadow = sp_shadow_q;
    assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, reset corner case,
// then random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_port_arbiter_if bus();

    wb_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        logic       s;
        logic [7:0] sd;
        logic       e_wen;
        logic [1:0] e_a;
        logic [7:0] e_d;
        logic [1:0] e_q;
        logic       e_st;
        logic [7:0] e_sh;
        logic       e_ov;
    } vec_t;

    vec_t tv[$];

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic       m_wen;
    logic [1:0] m_a;
    logic [7:0] m_d;
    logic [7:0] m_sh;
    logic       m_ov;
    logic [7:0] mq[$];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic wen,
                           input logic [1:0] a, input logic [7:0] d,
                           input logic [1:0] q, input logic st,
                           input logic [7:0] sh, input logic ov);
        chk({tag, " rf_wen"}, {7'd0, bus.rf_wen}, {7'd0, wen});
        chk({tag, " rf_waddr"}, {6'd0, bus.rf_waddr}, {6'd0, a});
        chk({tag, " rf_wdata"}, bus.rf_wdata, d);
        chk({tag, " q_count"}, {6'd0, bus.q_count}, {6'd0, q});
        chk({tag, " stall_req"}, {7'd0, bus.stall_req}, {7'd0, st});
        chk({tag, " sp_shadow"}, bus.sp_shadow, sh);
        chk({tag, " ovf_err"}, {7'd0, bus.ovf_err}, {7'd0, ov});
    endtask

    task automatic drive(input logic w, input logic [1:0] a,
                         input logic [7:0] d, input logic s,
                         input logic [7:0] sd);
        bus.wb_wen  = w;
        bus.wb_addr = a;
        bus.wb_data = d;
        bus.sp_wen  = s;
        bus.sp_data = sd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_wen = 1'b0;
        m_a   = 2'd0;
        m_d   = 8'h00;
        m_sh  = 8'hFF;
        m_ov  = 1'b0;
        mq.delete();
    endtask

    // Spec priority rules applied to an abstract FIFO.
    task automatic model_step(input logic w, input logic [1:0] a,
                              input logic [7:0] d, input logic s,
                              input logic [7:0] sd);
        if (w && a == 2'd3) begin
            m_wen = 1'b1; m_a = 2'd3; m_d = d;
            mq.delete();
            m_sh = d;
        end else if (w) begin
            m_wen = 1'b1; m_a = a; m_d = d;
            if (s) begin
                if (mq.size() < 2) begin
                    mq.push_back(sd);
                    m_sh = sd;
                end else begin
                    m_ov = 1'b1;
                end
            end
        end else if (mq.size() > 0) begin
            m_wen = 1'b1; m_a = 2'd3; m_d = mq.pop_front();
            if (s) begin
                mq.push_back(sd);
                m_sh = sd;
            end
        end else if (s) begin
            m_wen = 1'b1; m_a = 2'd3; m_d = sd;
            m_sh = sd;
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_all("reset", 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       w, s;
        logic [1:0] a;
        logic [7:0] d, sd;
        logic [1:0] eq;

        drive(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);

        // direct SP write
        tv.push_back('{0,0,8'h00,1,8'hFE, 1,3,8'hFE,0,0,8'hFE,0});
        tv.push_back('{0,0,8'h00,0,8'h00, 0,3,8'hFE,0,0,8'hFE,0});
        // single POP
        tv.push_back('{1,1,8'h5A,1,8'hFF, 1,1,8'h5A,1,0,8'hFF,0});
        tv.push_back('{0,0,8'h00,0,8'h00, 1,3,8'hFF,0,0,8'hFF,0});
        tv.push_back('{0,0,8'h00,0,8'h00, 0,3,8'hFF,0,0,8'hFF,0});
        // three back-to-back POPs, third overflows
        tv.push_back('{1,1,8'h11,1,8'hFD, 1,1,8'h11,1,0,8'hFD,0});
        tv.push_back('{1,2,8'h22,1,8'hFE, 1,2,8'h22,2,1,8'hFE,0});
        tv.push_back('{1,0,8'h33,1,8'hFF, 1,0,8'h33,2,1,8'hFE,1});
        tv.push_back('{0,0,8'h00,0,8'h00, 1,3,8'hFD,1,0,8'hFE,1});
        tv.push_back('{0,0,8'h00,0,8'h00, 1,3,8'hFE,0,0,8'hFE,1});
        tv.push_back('{0,0,8'h00,0,8'h00, 0,3,8'hFE,0,0,8'hFE,1});
        // push+pop on FULL
        tv.push_back('{1,1,8'h44,1,8'hF0, 1,1,8'h44,1,0,8'hF0,1});
        tv.push_back('{1,2,8'h55,1,8'hF1, 1,2,8'h55,2,1,8'hF1,1});
        tv.push_back('{0,0,8'h00,1,8'hF2, 1,3,8'hF0,2,1,8'hF2,1});
        tv.push_back('{0,0,8'h00,0,8'h00, 1,3,8'hF1,1,0,8'hF2,1});
        tv.push_back('{0,0,8'h00,0,8'h00, 1,3,8'hF2,0,0,8'hF2,1});
        // explicit R3 write flushes a full queue
        tv.push_back('{1,1,8'h66,1,8'hE0, 1,1,8'h66,1,0,8'hE0,1});
        tv.push_back('{1,2,8'h77,1,8'hE1, 1,2,8'h77,2,1,8'hE1,1});
        tv.push_back('{1,3,8'h80,1,8'hE2, 1,3,8'h80,0,0,8'h80,1});
        tv.push_back('{0,0,8'h00,0,8'h00, 0,3,8'h80,0,0,8'h80,1});
        tv.push_back('{0,0,8'h00,0,8'h00, 0,3,8'h80,0,0,8'h80,1});

        do_reset();

        foreach (tv[i]) begin
            drive(tv[i].w, tv[i].a, tv[i].d, tv[i].s, tv[i].sd);
            step();
            chk_all($sformatf("vec%0d", i), tv[i].e_wen, tv[i].e_a,
                    tv[i].e_d, tv[i].e_q, tv[i].e_st, tv[i].e_sh,
                    tv[i].e_ov);
        end

        // reset while the queue holds two entries
        drive(1'b1, 2'd1, 8'h01, 1'b1, 8'h10);
        step();
        drive(1'b1, 2'd2, 8'h02, 1'b1, 8'h11);
        step();
        chk("mid q_count", {6'd0, bus.q_count}, 8'd2);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("post_rst%0d", k), 1'b0, 2'd0, 8'h00,
                    2'd0, 1'b0, 8'hFF, 1'b0);
        end

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) begin
                do_reset();
            end
            w  = ($urandom_range(0, 99) < 45);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            s  = ($urandom_range(0, 99) < 55);
            sd = 8'($urandom);
            drive(w, a, d, s, sd);
            step();
            model_step(w, a, d, s, sd);
            eq = 2'(mq.size());
            chk_all($sformatf("rnd%0d", n), m_wen, m_a, m_d, eq,
                    (mq.size() == 2), m_sh, m_ov);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
